// File: rtl/bar_graph_pkg.sv
// Shared helpers for the LED bar graph: level-width sizing and thermometer encoding.
// Purely combinational functions; no latency of their own.
// No flow control; evaluated wherever they are called.
package bar_graph_pkg;

    // Widest bar the thermometer function can produce; callers cast down to their width.
    localparam int THERMO_MAX = 64;

    // Bits needed to hold the values 0..n, never less than 1.
    function automatic int lvl_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < (64'(n) + 64'd1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Lowest `level` bits set, limited to `width` bits; higher bits are always 0.
    function automatic logic [THERMO_MAX-1:0] thermo(input int level, input int width);
        logic [THERMO_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < THERMO_MAX; i++) begin
            if ((i < width) && (level > i)) begin
                t[i] = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/bar_graph_thermo.sv
// Level to thermometer encoder: bar_o has the lowest level_i segments set.
// Combinational, zero latency.
// No flow control; output follows input continuously.
module bar_graph_thermo #(
    parameter int WIDTH = 8,
    parameter int LVL_W = 4
) (
    input  logic [LVL_W-1:0] level_i,
    output logic [WIDTH-1:0] bar_o
);
    import bar_graph_pkg::*;

    // WIDTH must not exceed THERMO_MAX; the cast keeps only the live segments.
    assign bar_o = WIDTH'(thermo(32'(level_i), WIDTH));

endmodule

// File: rtl/bar_graph.sv
// Binary word to thermometer LED bar, optional peak-hold dot (BAR_GRAPH_PEAK_HOLD_EN).
// Latency 1: data sampled on the en edge, bar shows it after that edge.
// No backpressure; en=0 freezes the bar, async active-high rst clears it.
module bar_graph #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int LSB        = 0,
    parameter int PEAK_DECAY = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  data,
    output logic [OUT_WIDTH-1:0] bar
);
    import bar_graph_pkg::*;

    localparam int LVL_W = lvl_width(OUT_WIDTH);
    localparam int VW    = IN_WIDTH - LSB;
    // Compare width covers both the sliced value and OUT_WIDTH so nothing truncates.
    localparam int CW    = (VW > LVL_W) ? VW : LVL_W;

    logic [CW-1:0]        v_ext;
    logic [LVL_W-1:0]     level;
    logic [OUT_WIDTH-1:0] therm_lvl;
    logic [OUT_WIDTH-1:0] bar_d;
    logic [OUT_WIDTH-1:0] bar_q;

    // Bits below LSB are discarded by the coarse scaling.
    generate
        if (LSB > 0) begin : g_lsb_drop
            logic unused_lsb;
            assign unused_lsb = ^data[LSB-1:0];
        end
    endgenerate

    assign v_ext = CW'(data[IN_WIDTH-1:LSB]);
    assign level = (v_ext > CW'(OUT_WIDTH)) ? LVL_W'(OUT_WIDTH) : LVL_W'(v_ext);

    bar_graph_thermo #(
        .WIDTH (OUT_WIDTH),
        .LVL_W (LVL_W)
    ) u_thermo_lvl (
        .level_i (level),
        .bar_o   (therm_lvl)
    );

`ifdef BAR_GRAPH_PEAK_HOLD_EN
    // Counter only needs to reach PEAK_DECAY-1; sizing for 0..PEAK_DECAY is ample.
    localparam int CNT_W = lvl_width(PEAK_DECAY);

    logic [LVL_W-1:0]     peak_q;
    logic [LVL_W-1:0]     peak_d;
    logic [LVL_W-1:0]     peak_m1;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [OUT_WIDTH-1:0] therm_pk;
    logic [OUT_WIDTH-1:0] therm_pk_m1;
    logic [OUT_WIDTH-1:0] peak_dot;

    // Peak tracks new highs instantly and sinks one segment every PEAK_DECAY lower strobes.
    always_comb begin
        peak_d = peak_q;
        cnt_d  = cnt_q;
        if (en) begin
            if (level >= peak_q) begin
                peak_d = level;
                cnt_d  = '0;
            end else if (cnt_q == CNT_W'(PEAK_DECAY - 1)) begin
                peak_d = peak_q - LVL_W'(1);
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // Dot sits at segment peak-1: difference of two adjacent thermometer codes.
    assign peak_m1 = (peak_d == '0) ? '0 : (peak_d - LVL_W'(1));

    bar_graph_thermo #(
        .WIDTH (OUT_WIDTH),
        .LVL_W (LVL_W)
    ) u_thermo_pk (
        .level_i (peak_d),
        .bar_o   (therm_pk)
    );

    bar_graph_thermo #(
        .WIDTH (OUT_WIDTH),
        .LVL_W (LVL_W)
    ) u_thermo_pk_m1 (
        .level_i (peak_m1),
        .bar_o   (therm_pk_m1)
    );

    assign peak_dot = therm_pk & ~therm_pk_m1;
    assign bar_d    = therm_lvl | peak_dot;

    // Peak and decay counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
            cnt_q  <= '0;
        end else begin
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign bar_d = therm_lvl;
`endif

    // Output register: loads only on the en strobe, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_q <= '0;
        end else if (en) begin
            bar_q <= bar_d;
        end
    end

    assign bar = bar_q;

endmodule

// File: tb/tb_bar_graph.sv
// Self-checking bench for bar_graph: reset, ramp, saturation, hold, scaling, optional peak hold.
// Expected bars come from a small bench-side model pushed to a scoreboard queue.
// Outputs sampled 1 time unit after the rising edge.
module tb_bar_graph;

    localparam int PD = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] bar;
    logic       en2  = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic [7:0] bar2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } sb_t;
    sb_t sb_q[$];

    // Bench model state for the LSB=0 instance
    logic [7:0] m_bar  = 8'h00;
    int         m_peak = 0;
    int         m_cnt  = 0;

    always #5 clk = ~clk;

    bar_graph #(
        .IN_WIDTH   (8),
        .OUT_WIDTH  (8),
        .LSB        (0),
        .PEAK_DECAY (PD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .data (data),
        .bar  (bar)
    );

    bar_graph #(
        .IN_WIDTH   (8),
        .OUT_WIDTH  (8),
        .LSB        (4),
        .PEAK_DECAY (PD)
    ) dut_scaled (
        .clk  (clk),
        .rst  (rst),
        .en   (en2),
        .data (data2),
        .bar  (bar2)
    );

    function automatic logic [7:0] therm8(input int lvl);
        logic [8:0] t;
        t = (9'd1 << lvl) - 9'd1;
        return t[7:0];
    endfunction

    task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, update the model, push the expectation, then pop and compare after the edge.
    task automatic drive(input logic e, input logic [7:0] d, input string tag);
        int   lvl;
        sb_t  ent;
        en   = e;
        data = d;
        if (e) begin
            lvl = (d > 8'd8) ? 8 : int'(d);
`ifdef BAR_GRAPH_PEAK_HOLD_EN
            if (lvl >= m_peak) begin
                m_peak = lvl;
                m_cnt  = 0;
            end else if (m_cnt == PD - 1) begin
                m_peak = m_peak - 1;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_bar = therm8(lvl) | ((m_peak > 0) ? (8'd1 << (m_peak - 1)) : 8'h00);
`else
            m_bar = therm8(lvl);
`endif
        end
        sb_q.push_back('{m_bar, tag});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: observed=empty expected=entry");
        end else begin
            ent = sb_q.pop_front();
            chk(bar, ent.exp, ent.tag);
        end
    endtask

    task automatic drive2(input logic [7:0] d, input logic [7:0] exp, input string tag);
        en2   = 1'b1;
        data2 = d;
        @(posedge clk);
        #1;
        chk(bar2, exp, tag);
        en2 = 1'b0;
    endtask

    task automatic model_reset();
        m_bar  = 8'h00;
        m_peak = 0;
        m_cnt  = 0;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk(bar, 8'h00, "reset_init");
        chk(bar2, 8'h00, "reset_init_scaled");
        @(posedge clk);
        #1;
        chk(bar, 8'h00, "reset_held_init");
        rst = 1'b0;
        model_reset();

        // No en: bar stays cleared whatever data does
        drive(1'b0, 8'h55, "idle_no_en");

        // Ramp through the full input range, then wrap to 0
        for (int d = 0; d < 256; d++) begin
            drive(1'b1, 8'(d), "ramp");
            if (d == 3) chk(bar, 8'h07, "ramp_3");
            if (d == 8) chk(bar, 8'hFF, "ramp_8");
        end
        chk(bar, 8'hFF, "ramp_255");
        drive(1'b1, 8'h00, "wrap");
`ifndef BAR_GRAPH_PEAK_HOLD_EN
        chk(bar, 8'h00, "wrap_off");
`endif

        // Saturation
        drive(1'b1, 8'd200, "sat_200");
        chk(bar, 8'hFF, "sat_200_const");
        drive(1'b1, 8'd8, "sat_8");
        chk(bar, 8'hFF, "sat_8_const");
        drive(1'b1, 8'd7, "sat_7");
`ifndef BAR_GRAPH_PEAK_HOLD_EN
        chk(bar, 8'h7F, "sat_7_const");
`endif

        // Hold with en low
        drive(1'b1, 8'd3, "hold_load");
`ifndef BAR_GRAPH_PEAK_HOLD_EN
        chk(bar, 8'h07, "hold_load_const");
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h80, "hold");
        end
`ifndef BAR_GRAPH_PEAK_HOLD_EN
        chk(bar, 8'h07, "hold_end_const");
`endif

        // Asynchronous reset mid-cycle from a full bar
        drive(1'b1, 8'd200, "pre_rst_full");
        chk(bar, 8'hFF, "pre_rst_full_const");
        #2;
        rst = 1'b1;
        #1;
        chk(bar, 8'h00, "async_rst_midcycle");
        en   = 1'b1;
        data = 8'd200;
        @(posedge clk);
        #1;
        chk(bar, 8'h00, "rst_held_with_en");
        en  = 1'b0;
        rst = 1'b0;
        model_reset();
        drive(1'b0, 8'd200, "post_rst_no_en");
        drive(1'b1, 8'd5, "first_after_rst");
        chk(bar, 8'h1F, "first_after_rst_const");

        // Coarse scaling, LSB=4
        drive2(8'h35, 8'h07, "scale_v3");
        drive2(8'hF0, 8'hFF, "scale_v15");
        drive2(8'h0F, 8'h00, "scale_v0");

`ifdef BAR_GRAPH_PEAK_HOLD_EN
        // Peak hold with PEAK_DECAY=2
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 8'd6, "peak_rise");
        chk(bar, 8'h3F, "peak_rise_const");
        drive(1'b1, 8'd2, "peak_hold");
        chk(bar, 8'h23, "peak_hold_const");
        drive(1'b1, 8'd2, "peak_decay_a");
        drive(1'b1, 8'd2, "peak_decay_b");
        chk(bar, 8'h13, "peak_decay_const");
`endif

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
